// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and constants
// for the UART command frame controller.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      OP,
      ADDR,
      LEN,
      DATA,
      CHK,
      DRAIN
   } state_t;

   localparam logic [1:0] ERR_LEN = 2'd0;
   localparam logic [1:0] ERR_CHK = 2'd1;
   localparam logic [1:0] ERR_TO  = 2'd2;
   localparam logic [1:0] ERR_OVR = 2'd3;

   localparam logic [7:0] SYNC_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// uart_frame_ctrl_if: register-write command
// channel with valid/ready handshake.
interface uart_frame_ctrl_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_op;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_addr,
      output cmd_wdata,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_addr,
      input  cmd_wdata,
      output cmd_ready
   );

endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload register file, one
// write port, one asynchronous read port.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // payload bytes land here; contents need no reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: sync hunt, frame sequencing,
// checksum/length/timeout checks, command burst.
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] SYNC        = SYNC_DEF,
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   uart_frame_ctrl_if.master cmd,
   output logic              busy,
   output logic              frm_err,
   output logic [1:0]        err_code,
   output logic [7:0]        err_cnt
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0] MAXL = 8'(MAX_LEN);

   state_t        state_q, state_n;
   logic [7:0]    idx_q, idx_n;
   logic [7:0]    len_q, len_n;
   logic [7:0]    op_q, op_n;
   logic [7:0]    addr_q, addr_n;
   logic [7:0]    chk_q, chk_n;
   logic [TW-1:0] tmo_q, tmo_n;
   logic          vld_q, vld_n;
   logic [7:0]    cop_q, cop_n;
   logic [7:0]    cadr_q, cadr_n;
   logic [7:0]    cdat_q, cdat_n;
   logic          busy_q, busy_n;
   logic          err_q, err_ev;
   logic [1:0]    code_q, code_n;
   logic [7:0]    cnt_q, cnt_n;
   logic          buf_we;
   logic [7:0]    buf_rdata;
   logic          hs;
   logic          last;

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx_q[AW-1:0]),
      .wdata (rx_data),
      .raddr (idx_n[AW-1:0]),
      .rdata (buf_rdata)
   );

   // next-state, datapath and error decisions
   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      len_n   = len_q;
      op_n    = op_q;
      addr_n  = addr_q;
      chk_n   = chk_q;
      tmo_n   = '0;
      vld_n   = vld_q;
      cop_n   = cop_q;
      cadr_n  = cadr_q;
      cdat_n  = cdat_q;
      err_ev  = 1'b0;
      code_n  = code_q;
      buf_we  = 1'b0;
      hs      = vld_q & cmd.cmd_ready;
      last    = (idx_q == len_q - 8'd1);

      unique case (state_q)
         IDLE: begin
            if (rx_valid && rx_data == SYNC) state_n = OP;
         end
         OP: begin
            if (rx_valid) begin
               op_n    = rx_data;
               chk_n   = rx_data;
               state_n = ADDR;
            end
         end
         ADDR: begin
            if (rx_valid) begin
               addr_n  = rx_data;
               chk_n   = chk_q ^ rx_data;
               state_n = LEN;
            end
         end
         LEN: begin
            if (rx_valid) begin
               if (rx_data == 8'd0 || rx_data > MAXL) begin
                  err_ev  = 1'b1;
                  code_n  = ERR_LEN;
                  state_n = IDLE;
               end else begin
                  len_n   = rx_data;
                  idx_n   = 8'd0;
                  chk_n   = chk_q ^ rx_data;
                  state_n = DATA;
               end
            end
         end
         DATA: begin
            if (rx_valid) begin
               buf_we = 1'b1;
               chk_n  = chk_q ^ rx_data;
               if (last) state_n = CHK;
               else      idx_n   = idx_q + 8'd1;
            end
         end
         CHK: begin
            if (rx_valid) begin
               if (rx_data == chk_q) begin
                  idx_n   = 8'd0;
                  vld_n   = 1'b1;
                  cop_n   = op_q;
                  cadr_n  = addr_q;
                  cdat_n  = buf_rdata;
                  state_n = DRAIN;
               end else begin
                  err_ev  = 1'b1;
                  code_n  = ERR_CHK;
                  state_n = IDLE;
               end
            end
         end
         DRAIN: begin
            if (rx_valid) begin
               err_ev = 1'b1;
               code_n = ERR_OVR;
            end
            if (hs) begin
               if (last) begin
                  vld_n   = 1'b0;
                  state_n = IDLE;
               end else begin
                  idx_n  = idx_q + 8'd1;
                  cadr_n = addr_q + idx_n;
                  cdat_n = buf_rdata;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_q inside {OP, ADDR, LEN, DATA, CHK} && !rx_valid) begin
         if (tmo_q == TMO_LAST) begin
            err_ev  = 1'b1;
            code_n  = ERR_TO;
            state_n = IDLE;
         end else begin
            tmo_n = tmo_q + TW'(1);
         end
      end

      busy_n = (state_n != IDLE);
      cnt_n  = (err_ev && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
   end

   // state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         chk_q   <= '0;
         tmo_q   <= '0;
         vld_q   <= 1'b0;
         cop_q   <= '0;
         cadr_q  <= '0;
         cdat_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         len_q   <= len_n;
         op_q    <= op_n;
         addr_q  <= addr_n;
         chk_q   <= chk_n;
         tmo_q   <= tmo_n;
         vld_q   <= vld_n;
         cop_q   <= cop_n;
         cadr_q  <= cadr_n;
         cdat_q  <= cdat_n;
         busy_q  <= busy_n;
         err_q   <= err_ev;
         code_q  <= code_n;
         cnt_q   <= cnt_n;
      end
   end

   assign cmd.cmd_valid = vld_q;
   assign cmd.cmd_op    = cop_q;
   assign cmd.cmd_addr  = cadr_q;
   assign cmd.cmd_wdata = cdat_q;
   assign busy          = busy_q;
   assign frm_err       = err_q;
   assign err_code      = code_q;
   assign err_cnt       = cnt_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized
// frames against a byte-level reference model.
module tb_uart_frame_ctrl;
   import uart_frame_pkg::*;

   localparam int T  = 200;
   localparam int ML = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       busy, frm_err;
   logic [1:0] err_code;
   logic [7:0] err_cnt;
   logic [23:0] word;

   uart_frame_ctrl_if bus();

   uart_frame_ctrl #(
      .SYNC        (SYNC_DEF),
      .MAX_LEN     (ML),
      .TIMEOUT_CYC (T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .cmd      (bus),
      .busy     (busy),
      .frm_err  (frm_err),
      .err_code (err_code),
      .err_cnt  (err_cnt)
   );

   assign word = {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata};

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [23:0] obs[$];
   logic [23:0] exp_q[$];
   logic [7:0]  pl[$];
   int rd = 0;
   int pulses = 0;
   int events = 0;
   int err_total = 0;
   logic [1:0] exp_code = ERR_LEN;
   bit bp_en = 1'b0;
   logic ready_force = 1'b1;

   // record every accepted command word and every error pulse
   always @(posedge clk) begin
      if (bus.cmd_valid && bus.cmd_ready)
         obs.push_back(word);
      if (frm_err) pulses++;
   end

   // consumer ready: forced level or random backpressure
   initial begin
      bus.cmd_ready = 1'b1;
      forever begin
         @(negedge clk);
         bus.cmd_ready = bp_en ? ($urandom_range(0, 2) != 0) : ready_force;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] o,
                        input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic model_err(input logic [1:0] c);
      events++;
      err_total++;
      exp_code = c;
   endtask

   task automatic check_stats(input string tag);
      repeat (2) @(negedge clk);
      check({tag, "_cnt"}, err_cnt, (err_total > 255) ? 255 : err_total);
      check({tag, "_code"}, err_code, exp_code);
      check({tag, "_pulses"}, pulses, events);
   endtask

   task automatic check_words(input string tag);
      check({tag, "_nwords"}, obs.size() - rd, exp_q.size());
      foreach (exp_q[i])
         check(tag, (rd + i < obs.size()) ? {8'h00, obs[rd + i]}
                                          : 32'hDEADBEEF,
               {8'h00, exp_q[i]});
      rd = obs.size();
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", busy, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                             input logic [7:0] len, input bit bad,
                             input int gap);
      logic [7:0] c;
      send_byte(SYNC_DEF);
      send_byte(op);
      send_byte(addr);
      send_byte(len);
      if (len == 8'd0 || int'(len) > ML) begin
         model_err(ERR_LEN);
      end else begin
         c = op ^ addr ^ len;
         for (int i = 0; i < int'(len); i++) begin
            repeat ($urandom_range(0, gap)) @(negedge clk);
            send_byte(pl[i]);
            c ^= pl[i];
         end
         send_byte(bad ? ~c : c);
         if (bad) model_err(ERR_CHK);
         else
            for (int i = 0; i < int'(len); i++)
               exp_q.push_back({op, addr + 8'(i), pl[i]});
      end
   endtask

   initial begin
      logic [23:0] w0;
      bit stable;
      logic [7:0] c;
      int kind, n;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_valid", bus.cmd_valid, 1'b0);
      check("rst_word", word, 24'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", {frm_err, err_code, err_cnt}, 11'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // good frame, exact burst timing
      pl = '{8'h11, 8'h22};
      send_frame(8'h01, 8'h10, 8'h02, 1'b0, 0);
      check("t1_v0", bus.cmd_valid, 1'b1);
      check("t1_w0", word, 24'h011011);
      @(negedge clk);
      check("t1_v1", bus.cmd_valid, 1'b1);
      check("t1_w1", word, 24'h011122);
      @(negedge clk);
      check("t1_end", {bus.cmd_valid, busy}, 2'b00);
      check_words("t1");
      check_stats("t1");

      // bad checksum
      send_frame(8'h01, 8'h10, 8'h02, 1'b1, 0);
      check("t2_pulse", frm_err, 1'b1);
      @(negedge clk);
      check("t2_once", frm_err, 1'b0);
      check_words("t2");
      check_stats("t2");

      // length errors, trailing bytes ignored
      pl.delete();
      send_frame(8'h01, 8'h10, 8'h00, 1'b0, 0);
      check_stats("t3a");
      send_frame(8'h01, 8'h10, 8'h11, 1'b0, 0);
      send_byte(8'h11);
      send_byte(8'h22);
      check("t3_busy", busy, 1'b0);
      check_stats("t3b");

      // timeout exactly T cycles after the last byte
      send_byte(SYNC_DEF);
      send_byte(8'h01);
      repeat (T - 1) @(negedge clk);
      check("t4_early", {frm_err, busy}, 2'b01);
      @(negedge clk);
      check("t4_pulse", {frm_err, busy}, 2'b10);
      model_err(ERR_TO);
      pl = '{8'h11, 8'h22};
      send_frame(8'h01, 8'h10, 8'h02, 1'b0, 0);
      wait_idle(10);
      check_words("t4");
      check_stats("t4");

      // byte arriving on the timeout edge wins
      send_byte(SYNC_DEF);
      send_byte(8'h03);
      repeat (T - 1) @(negedge clk);
      send_byte(8'h20);
      check("t4b_win", {frm_err, busy}, 2'b01);
      send_byte(8'h01);
      send_byte(8'h77);
      c = 8'h03 ^ 8'h20 ^ 8'h01 ^ 8'h77;
      send_byte(c);
      exp_q.push_back(24'h032077);
      wait_idle(10);
      check_words("t4b");
      check_stats("t4b");

      // backpressure hold, overrun, SYNC value as data
      ready_force = 1'b0;
      repeat (2) @(negedge clk);
      pl = '{8'h5A, SYNC_DEF, 8'h3C};
      send_frame(8'h07, 8'h40, 8'h03, 1'b0, 0);
      check("t5_w0", {7'h0, bus.cmd_valid, word}, 32'h0107405A);
      w0 = word;
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) begin
            send_byte(8'h99);
            check("t5_ovr", frm_err, 1'b1);
            model_err(ERR_OVR);
         end else begin
            @(negedge clk);
         end
         if (!bus.cmd_valid || word !== w0) stable = 1'b0;
      end
      check("t5_stable", stable, 1'b1);
      check("t5_code", err_code, ERR_OVR);
      ready_force = 1'b1;
      wait_idle(20);
      check_words("t5");
      check_stats("t5");

      // address wrap
      pl = '{8'hAA, 8'hBB};
      send_frame(8'h02, 8'hFF, 8'h02, 1'b0, 0);
      wait_idle(10);
      check_words("t6_wrap");

      // randomized frames with random backpressure
      bp_en = 1'b1;
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 9);
         if (kind == 9) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
               c = 8'($urandom);
               send_byte((c == SYNC_DEF) ? 8'h00 : c);
            end
         end else if (kind == 8) begin
            pl.delete();
            c = ($urandom_range(0, 1) != 0) ? 8'd0
                                           : 8'($urandom_range(ML + 1, 255));
            send_frame(8'($urandom), 8'($urandom), c, 1'b0, 0);
         end else begin
            n = $urandom_range(1, ML);
            pl.delete();
            for (int j = 0; j < n; j++) pl.push_back(8'($urandom));
            send_frame(8'($urandom), 8'($urandom), 8'(n), kind == 7, 2);
            wait_idle(400);
         end
      end
      bp_en = 1'b0;
      repeat (2) @(negedge clk);
      check_words("rand");
      check_stats("rand");

      // error counter saturation
      pl.delete();
      for (int f = 0; f < 300; f++)
         send_frame(8'h01, 8'h10, 8'h00, 1'b0, 0);
      check_stats("sat");

      // reset mid-DATA
      send_byte(SYNC_DEF);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h03);
      send_byte(8'h11);
      rst = 1'b1;
      #1;
      check("rst2_out", {bus.cmd_valid, word, busy, frm_err, err_code, err_cnt},
            37'h0);
      @(negedge clk);
      rst = 1'b0;
      err_total = 0;
      exp_code = ERR_LEN;
      @(negedge clk);
      pl = '{8'h11, 8'h22};
      send_frame(8'h01, 8'h10, 8'h02, 1'b0, 0);
      wait_idle(10);
      check_words("rst2");
      check_stats("rst2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
